cache_arbiter: RTL and testbench

// Shares one burst physical-memory port between the I-cache and D-cache miss paths below cpu_datapath.

---
 rtl/cache_arbiter_if.sv | 41 ++++
 rtl/cache_arbiter.sv | 112 +++++++++++
 tb/tb_cache_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter_if
// Brief    : I-cache / D-cache line request bundle plus burst memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_arbiter_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
);
    logic               i_read;
    logic [31:0]        i_addr;
    logic [LINE_W-1:0]  i_rdata;
    logic               i_resp;
    logic               d_read;
    logic               d_write;
    logic [31:0]        d_addr;
    logic [LINE_W-1:0]  d_wdata;
    logic [LINE_W-1:0]  d_rdata;
    logic               d_resp;
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        mem_addr;
    logic [BURST_W-1:0] mem_wdata;
    logic [BURST_W-1:0] mem_rdata;
    logic               mem_resp;
    logic               stall;

    // Arbiter side
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata, stall
    );

    // Cache / memory environment side
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata, stall
    );
endinterface
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Brief    : Shares one burst memory port between I-cache and D-cache misses.
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int LINE_W    = 256,
    parameter int BURST_W   = 64,
    parameter int BURST_LEN = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    cache_arbiter_if.slave bus
);
    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BEAT_W-1:0]   beat;
    logic                gnt_d;
    logic [31:5]         addr_q;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rline_q;
    logic                in_burst;
    logic                beat_done;
    logic                last_beat;

    assign in_burst  = (state == I_RD) || (state == D_RD) || (state == D_WR);
    assign beat_done = in_burst && bus.mem_resp;
    assign last_beat = (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            beat    <= '0;
            gnt_d   <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state <= state_nxt;
            // Latch the winner in the same priority order as the next-state logic
            if (state == IDLE) begin
                if (bus.d_write || bus.d_read) begin
                    gnt_d  <= 1'b1;
                    addr_q <= bus.d_addr[31:5];
                end else if (bus.i_read) begin
                    gnt_d  <= 1'b0;
                    addr_q <= bus.i_addr[31:5];
                end
                if (bus.d_write) begin
                    wline_q <= bus.d_wdata;
                end
            end
            if (beat_done) begin
                beat <= last_beat ? '0 : beat + BEAT_W'(1);
                if (state != D_WR) begin
                    rline_q[32'(beat) * BURST_W +: BURST_W] <= bus.mem_rdata;
                end
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_resp    = 1'b0;
        bus.d_resp    = 1'b0;
        bus.i_rdata   = rline_q;
        bus.d_rdata   = rline_q;
        bus.stall     = (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.d_write)     state_nxt = D_WR;
                else if (bus.d_read) state_nxt = D_RD;
                else if (bus.i_read) state_nxt = I_RD;
            end
            I_RD, D_RD: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = {addr_q, 5'b0};
                if (beat_done && last_beat) state_nxt = DONE;
            end
            D_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {addr_q, 5'b0};
                bus.mem_wdata = wline_q[32'(beat) * BURST_W +: BURST_W];
                if (beat_done && last_beat) state_nxt = DONE;
            end
            DONE: begin
                bus.i_resp = !gnt_d;
                bus.d_resp = gnt_d;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Brief    : Directed scoreboard bench for cache_arbiter with a burst memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int BW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_W(LW), .BURST_W(BW)) bus ();
    cache_arbiter #(.LINE_W(LW), .BURST_W(BW), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [63:0] wdata; } beat_t;
    typedef struct { logic chk; logic [255:0] data; } resp_t;

    beat_t        exp_beats[$];
    resp_t        exp_i[$];
    resp_t        exp_d[$];
    logic [255:0] mem_img [logic [31:0]];
    int           checks   = 0;
    int           errors   = 0;
    int           wait_cfg = 0;
    int           mbeat    = 0;
    int           wcnt     = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected_or_missing required=expected_event", name);
    endtask

    function automatic void push_burst(input logic wr, input logic [31:0] a, input logic [255:0] line);
        for (int k = 0; k < 4; k++) exp_beats.push_back('{wr, a, wr ? line[k*64 +: 64] : 64'h0});
    endfunction

    // Memory model: wait_cfg idle cycles before every beat, data looked up by line address
    initial begin
        logic [255:0] line;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mbeat = 0; wcnt = 0; bus.mem_resp = 1'b0;
            end else begin
                if (bus.mem_resp) mbeat = (mbeat + 1) % 4;
                if (bus.mem_read || bus.mem_write) begin
                    if (wcnt < wait_cfg) begin bus.mem_resp = 1'b0; wcnt++; end
                    else begin bus.mem_resp = 1'b1; wcnt = 0; end
                end else begin
                    bus.mem_resp = 1'b0; wcnt = 0;
                end
            end
            line = mem_img.exists(bus.mem_addr) ? mem_img[bus.mem_addr] : '0;
            bus.mem_rdata = bus.mem_resp ? line[mbeat*64 +: 64] : 64'h0;
        end
    end

    // Monitor: compares every beat and response against the scoreboard queues
    initial begin
        beat_t eb;
        resp_t er;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                chk("stall", bus.stall, bus.mem_read | bus.mem_write | bus.i_resp | bus.d_resp);
                if (bus.mem_read || bus.mem_write) begin
                    if (bus.mem_resp) begin
                        if (exp_beats.size() == 0) flag("unexpected_beat");
                        else begin
                            eb = exp_beats.pop_front();
                            chk("beat_dir", {bus.mem_write, bus.mem_read}, eb.wr ? 2'b10 : 2'b01);
                            chk("beat_addr", bus.mem_addr, eb.addr);
                            if (eb.wr) chk("beat_wdata", bus.mem_wdata, eb.wdata);
                        end
                    end
                end else begin
                    chk("idle_addr_wdata", {bus.mem_addr, bus.mem_wdata}, '0);
                end
                if (bus.i_resp) begin
                    if (exp_i.size() == 0) flag("unexpected_i_resp");
                    else begin
                        er = exp_i.pop_front();
                        if (er.chk) chk("i_rdata", bus.i_rdata, er.data);
                    end
                end
                if (bus.d_resp) begin
                    if (exp_d.size() == 0) flag("unexpected_d_resp");
                    else begin
                        er = exp_d.pop_front();
                        if (er.chk) chk("d_rdata", bus.d_rdata, er.data);
                    end
                end
            end
        end
    end

    task automatic drv_i(input logic [31:0] a, output int lat);
        bus.i_addr = a; bus.i_read = 1'b1; lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.i_resp) begin lat = c; break; end
        end
        bus.i_read = 1'b0;
        if (lat < 0) flag("i_resp_timeout");
    endtask

    task automatic drv_d(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [255:0] wd, output int lat);
        bus.d_addr = a; bus.d_wdata = wd; bus.d_read = rd; bus.d_write = wr; lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.d_resp) begin lat = c; break; end
        end
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        if (lat < 0) flag("d_resp_timeout");
    endtask

    task automatic all_zero(input string name);
        chk({name, "_ctl"}, {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp, bus.stall}, '0);
        chk({name, "_addr_wdata"}, {bus.mem_addr, bus.mem_wdata}, '0);
        chk({name, "_i_rdata"}, bus.i_rdata, '0);
        chk({name, "_d_rdata"}, bus.d_rdata, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l1, w2, l3d, l3i, l4, l5, w6, l6;
        int lat, latd, lati, lowcnt, lat1, lat2;
        bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.d_addr = '0;   bus.d_wdata = '0;
        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        w2  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        l3d = {64'hD303_0000_0000_0003, 64'hD302_0000_0000_0002, 64'hD301_0000_0000_0001, 64'hD300_0000_0000_0000};
        l3i = {64'hA203_0000_0000_0003, 64'hA202_0000_0000_0002, 64'hA201_0000_0000_0001, 64'hA200_0000_0000_0000};
        l4  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0};
        l5  = {64'h5555_0003_0000_0000, 64'h5555_0002_0000_0000, 64'h5555_0001_0000_0000, 64'h5555_0000_0000_0000};
        w6  = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
        l6  = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        mem_img[32'h0000_0060] = l1;
        mem_img[32'h0000_0300] = l3d;
        mem_img[32'h0000_0200] = l3i;
        mem_img[32'h0000_0480] = l4;
        mem_img[32'h0000_0600] = l5;
        mem_img[32'h1000_0800] = l6;

        repeat (3) @(negedge clk);
        #1 all_zero("reset");
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // I-cache read, zero-wait memory
        exp_i.push_back('{1'b1, l1});
        push_burst(1'b0, 32'h0000_0060, '0);
        drv_i(32'h0000_0060, lat);
        chk("i_rd_latency", lat, 5);
        repeat (2) @(negedge clk);

        // D-cache write-back, address low bits forced to zero
        exp_d.push_back('{1'b0, '0});
        push_burst(1'b1, 32'h1000_0000, w2);
        drv_d(32'h1000_0013, 1'b0, 1'b1, w2, lat);
        chk("d_wr_latency", lat, 5);
        repeat (2) @(negedge clk);

        // Simultaneous I and D reads: D first, one IDLE cycle between bursts
        push_burst(1'b0, 32'h0000_0300, '0);
        push_burst(1'b0, 32'h0000_0200, '0);
        exp_d.push_back('{1'b1, l3d});
        exp_i.push_back('{1'b1, l3i});
        lowcnt = 0;
        fork
            drv_d(32'h0000_0300, 1'b1, 1'b0, '0, latd);
            drv_i(32'h0000_0200, lati);
            for (int c = 0; c < 11; c++) begin
                @(negedge clk); #1;
                if (!bus.stall) lowcnt++;
            end
        join
        chk("both_d_latency", latd, 5);
        chk("both_i_latency", lati, 11);
        chk("both_stall_low_cycles", lowcnt, 1);
        repeat (2) @(negedge clk);

        // Three wait states before every beat
        wait_cfg = 3;
        exp_i.push_back('{1'b1, l4});
        push_burst(1'b0, 32'h0000_0480, '0);
        drv_i(32'h0000_0480, lat);
        chk("wait_latency", lat, 17);
        wait_cfg = 0;
        repeat (2) @(negedge clk);

        // Reset after two beats of a D read: abandoned, no response
        exp_beats.push_back('{1'b0, 32'h0000_0600, 64'h0});
        exp_beats.push_back('{1'b0, 32'h0000_0600, 64'h0});
        bus.d_addr = 32'h0000_0600; bus.d_read = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; bus.d_read = 1'b0;
        @(negedge clk);
        #1 all_zero("midburst_reset");
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_i.push_back('{1'b1, l1});
        push_burst(1'b0, 32'h0000_0060, '0);
        drv_i(32'h0000_0060, lat);
        chk("post_reset_latency", lat, 5);
        repeat (2) @(negedge clk);

        // d_read and d_write together: write first, then the read
        exp_d.push_back('{1'b0, '0});
        exp_d.push_back('{1'b1, l6});
        push_burst(1'b1, 32'h1000_0800, w6);
        push_burst(1'b0, 32'h1000_0800, '0);
        bus.d_addr = 32'h1000_0800; bus.d_wdata = w6; bus.d_read = 1'b1; bus.d_write = 1'b1;
        lat1 = -1; lat2 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.d_resp) begin
                if (lat1 < 0) begin lat1 = c; bus.d_write = 1'b0; end
                else begin lat2 = c; bus.d_read = 1'b0; break; end
            end
        end
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        chk("rw_first_latency", lat1, 5);
        chk("rw_second_latency", lat2, 11);
        repeat (3) @(negedge clk);

        chk("leftover_beats", exp_beats.size(), 0);
        chk("leftover_i", exp_i.size(), 0);
        chk("leftover_d", exp_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
